instr_fetch_unit: RTL

Sequential instruction-fetch front end for the 32-bit MIPS core. It owns the program counter, requests words from instruction memory over a req/ready handshake, and presents each instruction (and therefore its opcode) to the control unit and datapath under a valid/ack handshake. It also consumes the decoded branch/jump outcome to select the next PC. It sits between instruction memory and the opcode input of the control decoder.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/next_pc_calc.sv | 45 ++++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    // Fetch FSM state; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/next_pc_calc.sv
// Next-PC target arithmetic for the held instruction.
// Ports:
//   i_instr_pc     address of the held instruction
//   i_instr        held instruction word
//   i_jump         held instruction is a jump (priority over branch)
//   i_branch_taken branch resolved taken
//   o_next_pc_c    selected next program counter (combinational)
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [ADDR_W-1:0]  i_instr_pc,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_jump,
    input  logic               i_branch_taken,
    output logic [ADDR_W-1:0]  o_next_pc_c
);

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic              w_unused_opcode;

    // Sequential successor; wraps modulo 2^32.
    assign w_pc4 = i_instr_pc + ADDR_W'(PC_STEP);

    // Sign-extended word offset of the 16-bit immediate.
    assign w_br_off = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};

    // Region-relative jump keeps the upper nibble of pc+4.
    assign w_jump_tgt = {w_pc4[31:28], i_instr[25:0], 2'b00};

    // Opcode field is decoded elsewhere.
    assign w_unused_opcode = ^i_instr[31:26];

    // Target select: jump beats branch beats fall-through.
    always_comb begin
        o_next_pc_c = w_pc4;
        if (i_jump) begin
            o_next_pc_c = w_jump_tgt;
        end else if (i_branch_taken) begin
            o_next_pc_c = w_pc4 + w_br_off;
        end
    end

endmodule : next_pc_calc

// File: rtl/instr_fetch_unit.sv
// Sequential instruction-fetch front end: owns the PC, fetches words over a
// req/ready handshake and holds each instruction under a valid/ack handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req/addr         fetch request and address (addr == pc)
//   imem_ready/rdata      memory response
//   instr/instr_pc        held instruction and its address
//   instr_valid/instr_ack datapath handshake
//   branch_taken/jump     control-flow outcome, sampled with instr_ack
//   retired_count         number of acknowledged instructions
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ack,
    input  logic               branch_taken,
    input  logic               jump,
    output logic [31:0]        retired_count
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic               w_capture;
    logic               w_retire;
    logic               r_imem_req;
    logic               r_instr_valid;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic [31:0]        r_retired_count;
    logic [ADDR_W-1:0]  w_next_pc;

    next_pc_calc u_next_pc_calc (
        .i_instr_pc     (r_instr_pc),
        .i_instr        (r_instr),
        .i_jump         (jump),
        .i_branch_taken (branch_taken),
        .o_next_pc_c    (w_next_pc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and register-enable decode.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    w_retire     = 1'b1;
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs registered from the next state, so they track the
    // state register exactly without any input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            r_imem_req    <= (w_state_next == FETCH);
            r_instr_valid <= (w_state_next == HOLD);
        end
    end

    // Instruction capture on a completed fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (w_capture) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
        end
    end

    // PC advance and retirement count on acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= RESET_PC;
            r_retired_count <= '0;
        end else if (w_retire) begin
            r_pc            <= w_next_pc;
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    assign imem_req      = r_imem_req;
    assign imem_addr     = r_pc;
    assign instr_valid   = r_instr_valid;
    assign instr         = r_instr;
    assign instr_pc      = r_instr_pc;
    assign retired_count = r_retired_count;

endmodule : instr_fetch_unit
